mp_add_sequencer: RTL and testbench

//  Multi-precision add/sub engine. Sequences one WORD_W-bit sklansky_adder over WORDS

---
 rtl/mp_add_pkg.sv | 16 +
 rtl/mp_add_sequencer_sklansky.sv | 53 +++++
 rtl/mp_add_sequencer.sv | 138 +++++++++++++
 tb/tb_mp_add_sequencer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mp_add_pkg.sv
// Shared types and default sizing for the multi-precision add/sub sequencer.
// Contents:
//   WORD_W_DEF / WORDS_DEF : default slice width and slice count
//   mp_state_t             : sequencer FSM state encoding
package mp_add_pkg;

    localparam int WORD_W_DEF = 8;
    localparam int WORDS_DEF  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mp_state_t;

endpackage

// File: rtl/mp_add_sequencer_sklansky.sv
// sklansky_adder: SIZE-bit parallel-prefix (Sklansky) adder, purely combinational.
// Ports:
//   a, b  in  SIZE  addends
//   cin   in  1     carry in
//   sum   out SIZE  a + b + cin (low SIZE bits)
//   cout  out 1     carry out of bit SIZE-1
module sklansky_adder #(
    parameter int SIZE = 8
) (
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    input  logic            cin,
    output logic [SIZE-1:0] sum,
    output logic            cout
);

    localparam int LV = $clog2(SIZE);

    logic [SIZE-1:0] g [0:LV];
    logic [SIZE-1:0] p [0:LV];
    logic [SIZE-1:0] prop;
    logic [SIZE:0]   c;

    always_comb begin
        prop = a ^ b;
        for (int l = 0; l <= LV; l++) begin
            g[l] = '0;
            p[l] = '0;
        end
        g[0] = a & b;
        p[0] = prop;
        // cin is folded into bit 0's generate, so the final prefix generate of
        // bit i is directly the carry into bit i+1.
        g[0][0] = (a[0] & b[0]) | (prop[0] & cin);
        for (int l = 0; l < LV; l++) begin
            for (int i = 0; i < SIZE; i++) begin
                if (((i >> l) & 1) == 1) begin
                    // combine with the last bit of the lower half of this 2^(l+1) group
                    g[l+1][i] = g[l][i] | (p[l][i] & g[l][((i >> l) << l) - 1]);
                    p[l+1][i] = p[l][i] & p[l][((i >> l) << l) - 1];
                end else begin
                    g[l+1][i] = g[l][i];
                    p[l+1][i] = p[l][i];
                end
            end
        end
        c[0]      = cin;
        c[SIZE:1] = g[LV];
        sum       = prop ^ c[SIZE-1:0];
        cout      = c[SIZE];
    end

endmodule

// File: rtl/mp_add_sequencer.sv
// mp_add_sequencer: multi-precision add/sub engine. One WORD_W-bit Sklansky adder
// is reused for WORDS cycles, least-significant word first, with the carry
// chained word to word through a register.
// Optional feature macro: MP_ADD_SUB_EN (enables in_sub = A - B).
// Ports:
//   clk, rst            clock / async active-high reset
//   in_valid/in_ready   operand handshake (in_ready only in IDLE)
//   in_a, in_b, in_cin  operands and carry-in
//   in_sub              subtract select (ignored without MP_ADD_SUB_EN)
//   out_valid/out_ready result handshake (out_valid only in DONE)
//   out_sum, out_cout   W-bit result and carry out of top word
//   out_ovf             two's-complement overflow of the W-bit result
//   busy                engine not idle
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// RUN   | one word per cycle through the shared adder
// DONE  | result held on outputs until consumer accepts
module mp_add_sequencer
    import mp_add_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int WORDS  = WORDS_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WORD_W*WORDS-1:0]  in_a,
    input  logic [WORD_W*WORDS-1:0]  in_b,
    input  logic                     in_cin,
    input  logic                     in_sub,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WORD_W*WORDS-1:0]  out_sum,
    output logic                     out_cout,
    output logic                     out_ovf,
    output logic                     busy
);

    localparam int W  = WORD_W * WORDS;
    localparam int CW = $clog2(WORDS) + 1;

    mp_state_t         state;
    logic [W-1:0]      a_sh;
    logic [W-1:0]      b_sh;
    logic [W-1:0]      sum_sh;
    logic              carry;
    logic [CW-1:0]     cnt;
    logic [W-1:0]      b_eff;
    logic              cin_eff;
    logic [WORD_W-1:0] slice_sum;
    logic              slice_cout;
    logic [W-1:0]      sum_next;
    logic              last_word;

`ifdef MP_ADD_SUB_EN
    assign b_eff   = in_sub ? ~in_b : in_b;
    assign cin_eff = in_sub ? 1'b1 : in_cin;
`else
    logic unused_sub;
    assign unused_sub = in_sub;
    assign b_eff      = in_b;
    assign cin_eff    = in_cin;
`endif

    sklansky_adder #(.SIZE(WORD_W)) u_slice_add (
        .a    (a_sh[WORD_W-1:0]),
        .b    (b_sh[WORD_W-1:0]),
        .cin  (carry),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // New sum word enters at the top; after WORDS shifts the register holds the result.
    assign sum_next  = (sum_sh >> WORD_W) | (W'(slice_sum) << (W - WORD_W));
    assign last_word = (cnt == CW'(WORDS - 1));
    assign out_sum   = sum_sh;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            sum_sh    <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            out_cout  <= 1'b0;
            out_ovf   <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_sh     <= in_a;
                        b_sh     <= b_eff;
                        carry    <= cin_eff;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> WORD_W;
                    b_sh   <= b_sh >> WORD_W;
                    sum_sh <= sum_next;
                    carry  <= slice_cout;
                    cnt    <= cnt + CW'(1);
                    if (last_word) begin
                        // the low slice of a_sh/b_sh now holds the original top word
                        out_cout  <= slice_cout;
                        out_ovf   <= (a_sh[WORD_W-1] == b_sh[WORD_W-1]) &&
                                     (slice_sum[WORD_W-1] != a_sh[WORD_W-1]);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mp_add_sequencer.sv
module tb_mp_add_sequencer;

    localparam int WORD_W = 8;
    localparam int WORDS  = 4;
    localparam int W      = WORD_W * WORDS;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic         in_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;
    logic         busy;

    mp_add_sequencer #(.WORD_W(WORD_W), .WORDS(WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           due;
    } exp_t;

    exp_t         q[$];
    logic [W-1:0] got_sum[$];
    logic         got_cout[$];
    logic         got_ovf[$];
    int           n_chk  = 0;
    int           n_fail = 0;
    int           cyc    = 0;
    int           bp_cnt = 0;
    bit           rnd_ready = 0;
    bit           prev_ov = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: timeout, no progress (t=%0t)", nm, $time);
    endtask

    // Reference: whole-width arithmetic on the full operands.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub, input int due);
        exp_t         r;
        logic [W-1:0] be;
        logic         ce;
        logic [W:0]   t;
        be = b;
        ce = cin;
`ifdef MP_ADD_SUB_EN
        if (sub) begin
            be = ~b;
            ce = 1'b1;
        end
`else
        if (sub) be = b;
`endif
        t     = {1'b0, a} + {1'b0, be} + (W+1)'(ce);
        r.sum  = t[W-1:0];
        r.cout = t[W];
        r.ovf  = (a[W-1] == be[W-1]) && (t[W-1] != a[W-1]);
        r.due  = due;
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (bp_cnt > 0) begin
            out_ready = 1'b0;
            bp_cnt    = bp_cnt - 1;
        end else begin
            out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            prev_ov = 1'b0;
        end else begin
            chk("busy", {63'd0, busy}, {63'd0, q.size() != 0});
            if (q.size() == 0) begin
                chk("no_spurious_valid", {63'd0, out_valid}, 64'd0);
            end else if (out_valid) begin
                if (!prev_ov) chk("latency", 64'(cyc), 64'(q[0].due));
                chk("sum", 64'(out_sum), 64'(q[0].sum));
                chk("cout", {63'd0, out_cout}, {63'd0, q[0].cout});
                chk("ovf", {63'd0, out_ovf}, {63'd0, q[0].ovf});
                chk("in_ready_in_done", {63'd0, in_ready}, 64'd0);
                if (out_ready) begin
                    got_sum.push_back(out_sum);
                    got_cout.push_back(out_cout);
                    got_ovf.push_back(out_ovf);
                    void'(q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                chk("accept_while_pending", 64'(q.size()), 64'd0);
                q.push_back(model(in_a, in_b, in_cin, in_sub, cyc + 1 + WORDS));
            end
            prev_ov = out_valid;
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub);
        @(posedge clk);
        #1;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_sub   = sub;
        in_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
        timeout_fail("send_accept");
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (q.size() == 0 && !busy) return;
        end
        timeout_fail("wait_idle");
    endtask

    task automatic chk_last(input string nm, input logic [W-1:0] s,
                            input logic c, input logic o);
        if (got_sum.size() == 0) begin
            timeout_fail({nm, "_no_result"});
        end else begin
            chk({nm, "_sum"}, 64'(got_sum[$]), 64'(s));
            chk({nm, "_cout"}, {63'd0, got_cout[$]}, {63'd0, c});
            chk({nm, "_ovf"}, {63'd0, got_ovf[$]}, {63'd0, o});
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        in_sub    = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sum", 64'(out_sum), 64'd0);
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_cout", {63'd0, out_cout}, 64'd0);
        chk("rst_ovf", {63'd0, out_ovf}, 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_rst", {63'd0, in_ready}, 64'd1);

        send(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
        wait_idle();
        chk_last("t1", 32'h0000_0100, 1'b0, 1'b0);

        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        wait_idle();
        chk_last("t2", 32'h0000_0000, 1'b1, 1'b0);

        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        wait_idle();
        chk_last("t3a", 32'h8000_0000, 1'b0, 1'b1);

        send(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        wait_idle();
        chk_last("t3b", 32'h0000_0000, 1'b1, 1'b1);

        // backpressure: requester holds in_valid with the next op through RUN/DONE
        bp_cnt = 12;
        send(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
        send(32'hFFFF_0000, 32'h0000_FFFF, 1'b1, 1'b0);
        wait_idle();
        chk_last("t4b", 32'h0000_0000, 1'b1, 1'b0);
        if (got_sum.size() >= 2)
            chk("t4a_sum", 64'(got_sum[got_sum.size()-2]), 64'h2345_6789);

        // reset in the middle of RUN
        send(32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_sum", 64'(out_sum), 64'd0);
        chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_busy", {63'd0, busy}, 64'd0);
        chk("mid_rst_ready", {63'd0, in_ready}, 64'd0);
        chk("mid_rst_cout", {63'd0, out_cout}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_ready", {63'd0, in_ready}, 64'd1);
        chk("post_rst_busy", {63'd0, busy}, 64'd0);
        repeat (8) @(posedge clk);

        send(32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1);
        wait_idle();
`ifdef MP_ADD_SUB_EN
        chk_last("t6", 32'hFFFF_FFFF, 1'b0, 1'b0);
`else
        chk_last("t6", 32'h0000_0001, 1'b0, 1'b0);
`endif

        rnd_ready = 1'b1;
        for (int n = 0; n < 40; n++) begin
            logic [W-1:0] ra, rb;
            ra = $urandom();
            rb = $urandom();
            case ($urandom_range(0, 5))
                0: ra = 32'hFFFF_FFFF;
                1: rb = 32'h8000_0000;
                2: rb = ~ra;
                default: ;
            endcase
            send(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
